// File: rtl/rl_record_serializer_pkg.sv
// Shared definitions for the RL02 record serializer and the CRC-16 stage it drives.
package rl_record_serializer_pkg;

  localparam int WORD_W = 16;
  localparam int CRC_W  = 16;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h8005;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLR      = 3'd1,
    ST_DATA     = 3'd2,
    ST_CRC_LOAD = 3'd3,
    ST_CRC      = 3'd4,
    ST_TAIL     = 3'd5
  } state_e;

endpackage

// File: rtl/rl_word_skid.sv
// Single-entry holding register between the sector buffer and the serializer shift register.
module rl_word_skid
  import rl_record_serializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              srst,
  input  logic              accept_en,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_full,
  input  logic              out_take
);

  logic              full_r;
  logic [WORD_W-1:0] data_r;

  assign in_ready = !full_r && accept_en;
  assign out_data = data_r;
  assign out_full = full_r;

  // Capture one word on handshake; release it when the shift register takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_r <= 1'b0;
      data_r <= '0;
    end else if (srst) begin
      full_r <= 1'b0;
    end else if (in_valid && in_ready) begin
      full_r <= 1'b1;
      data_r <= in_data;
    end else if (out_take) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

endmodule

// File: rtl/rl_record_serializer.sv
// Bit-serial record transmitter: data words LSB-first, then the CRC-16 MSB-first.
module rl_record_serializer
  import rl_record_serializer_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  rec_len,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              bit_tick,
  output logic              ser_out,
  output logic              ser_en,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              crc_clr,
  output logic              crc_en,
  output logic              crc_data,
  input  logic [CRC_W-1:0]  crc_in
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e            state_r;
  logic [LEN_W-1:0]  words_left_r;
  logic [LEN_W-1:0]  accept_left_r;
  logic [WORD_W-1:0] shift_r;
  logic              shift_full_r;
  logic [3:0]        bit_cnt_r;
  logic              ser_out_r;
  logic              ser_en_r;
  logic              busy_r;
  logic              done_r;
  logic              underrun_r;
  logic              crc_clr_r;

  logic              accept_en_s;
  logic              hs_s;
  logic              load_s;
  logic              data_tick_s;
  logic              idle_s;
  logic [WORD_W-1:0] hold_data_s;
  logic              hold_full_s;

  assign idle_s      = (state_r == ST_IDLE);
  assign accept_en_s = (accept_left_r != '0) && ((state_r == ST_DATA) || (state_r == ST_CLR));
  assign hs_s        = word_valid && word_ready;
  assign load_s      = (state_r == ST_DATA) && !shift_full_r && hold_full_s && !bit_tick;
  assign data_tick_s = (state_r == ST_DATA) && bit_tick && shift_full_r;

  // The CRC stage must advance on the very edge that shifts the bit out.
  assign crc_en   = data_tick_s;
  assign crc_data = shift_r[0];

  assign ser_out  = ser_out_r;
  assign ser_en   = ser_en_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign underrun = underrun_r;
  assign crc_clr  = crc_clr_r;

  rl_word_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .srst      (idle_s),
    .accept_en (accept_en_s),
    .in_data   (word_data),
    .in_valid  (word_valid),
    .in_ready  (word_ready),
    .out_data  (hold_data_s),
    .out_full  (hold_full_s),
    .out_take  (load_s)
  );

  // Record sequencer with registered line and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      words_left_r  <= '0;
      accept_left_r <= '0;
      shift_r       <= '0;
      shift_full_r  <= 1'b0;
      bit_cnt_r     <= 4'd0;
      ser_out_r     <= 1'b0;
      ser_en_r      <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      underrun_r    <= 1'b0;
      crc_clr_r     <= 1'b1;
    end else begin
      done_r <= 1'b0;
      if (hs_s) begin
        accept_left_r <= accept_left_r - LEN_ONE;
      end
      case (state_r)
        ST_IDLE: begin
          crc_clr_r <= 1'b0;
          if (start) begin
            words_left_r  <= rec_len;
            accept_left_r <= rec_len;
            underrun_r    <= 1'b0;
            busy_r        <= 1'b1;
            crc_clr_r     <= 1'b1;
            shift_full_r  <= 1'b0;
            state_r       <= ST_CLR;
          end
        end
        ST_CLR: begin
          crc_clr_r <= 1'b0;
          bit_cnt_r <= 4'd0;
          state_r   <= (words_left_r == '0) ? ST_CRC_LOAD : ST_DATA;
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (shift_full_r) begin
              ser_out_r <= shift_r[0];
              ser_en_r  <= 1'b1;
              shift_r   <= {1'b0, shift_r[WORD_W-1:1]};
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd15) begin
                shift_full_r <= 1'b0;
                words_left_r <= words_left_r - LEN_ONE;
                if (words_left_r == LEN_ONE) begin
                  state_r <= ST_CRC_LOAD;
                end
              end
            end else begin
              // Starved line: abort the record without a done pulse.
              underrun_r <= 1'b1;
              ser_en_r   <= 1'b0;
              ser_out_r  <= 1'b0;
              busy_r     <= 1'b0;
              state_r    <= ST_IDLE;
            end
          end else if (load_s) begin
            shift_r      <= hold_data_s;
            shift_full_r <= 1'b1;
          end
        end
        ST_CRC_LOAD: begin
          shift_r   <= crc_in;
          bit_cnt_r <= 4'd0;
          state_r   <= ST_CRC;
        end
        ST_CRC: begin
          if (bit_tick) begin
            ser_out_r <= shift_r[WORD_W-1];
            ser_en_r  <= 1'b1;
            shift_r   <= {shift_r[WORD_W-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd15) begin
              state_r <= ST_TAIL;
            end
          end
        end
        ST_TAIL: begin
          if (bit_tick) begin
            ser_out_r <= 1'b0;
            ser_en_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          ser_en_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rl_record_serializer.sv
// Self-checking bench: randomized records compared against a bit-stream reference model.
module tb_rl_record_serializer;
  import rl_record_serializer_pkg::*;

  localparam int LEN_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  rec_len;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              bit_tick;
  logic              ser_out;
  logic              ser_en;
  logic              busy;
  logic              done;
  logic              underrun;
  logic              crc_clr;
  logic              crc_en;
  logic              crc_data;
  logic [CRC_W-1:0]  crc_reg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] words_q[$];

  always #5 clk = ~clk;

  rl_record_serializer #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rec_len    (rec_len),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .bit_tick   (bit_tick),
    .ser_out    (ser_out),
    .ser_en     (ser_en),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun),
    .crc_clr    (crc_clr),
    .crc_en     (crc_en),
    .crc_data   (crc_data),
    .crc_in     (crc_reg)
  );

  // Stand-in for the existing serial CRC-16 stage wired by the parent.
  always @(posedge clk) begin
    if (crc_clr) crc_reg <= CRC_INIT;
    else if (crc_en) crc_reg <= {crc_reg[14:0], 1'b0} ^ ((crc_reg[15] ^ crc_data) ? CRC_POLY : 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Polynomial remainder of the bit sequence (first bit = highest power), no augmentation.
  function automatic logic [15:0] ref_crc(input logic bits[$], input int n);
    logic [15:0] r = CRC_INIT;
    for (int i = 0; i < n; i++) begin
      logic fb = r[15] ^ bits[i];
      r = r << 1;
      if (fb) r = r ^ CRC_POLY;
    end
    return r;
  endfunction

  task automatic run_record(input int len, input int n_supply, input int per, input int max_gap,
                            input int abort_tick, input int mid_start_cyc);
    logic exp_q[$];
    logic line_q[$];
    logic [15:0] dcrc;
    int nbits, end_tick, budget;
    int ti = 0, wi = 0, hs_cnt = 0, clr_cnt = 0, done_cnt = 0, gap = 0, cyc = 0;
    bit hs, tick_now, ready_seen = 0, fin = 0, aborted = 0, under_exp;
    for (int w = 0; w < len; w++)
      for (int b = 0; b < 16; b++) exp_q.push_back(words_q[w][b]);
    dcrc = ref_crc(exp_q, len * 16);
    for (int b = 15; b >= 0; b--) exp_q.push_back(dcrc[b]);
    nbits     = len * 16 + 16;
    under_exp = (n_supply < len);
    end_tick  = under_exp ? n_supply * 16 : nbits;
    budget    = (nbits + 2) * per + 200;

    rec_len    = len[LEN_W-1:0];
    start      = 1'b1;
    bit_tick   = 1'b0;
    word_valid = (n_supply > 0);
    word_data  = (words_q.size() > 0) ? words_q[0] : 16'h0000;
    while (!fin && cyc < budget) begin
      hs = word_valid && word_ready;
      if (word_ready) ready_seen = 1;
      tick_now = bit_tick;
      @(posedge clk); #1;
      cyc++;
      start = (cyc == mid_start_cyc);
      if (start) rec_len = 8'd5;
      if (cyc == 1) begin
        chk("busy_on_start", busy, 1);
        chk("underrun_cleared", underrun, 0);
      end
      if (crc_clr) clr_cnt++;
      if (done) done_cnt++;
      if (hs) begin
        hs_cnt++; wi++; word_valid = 1'b0;
        gap = $urandom_range(0, max_gap);
      end
      if (!word_valid && wi < n_supply) begin
        if (gap == 0) begin word_valid = 1'b1; word_data = words_q[wi]; end
        else gap--;
      end
      if (tick_now) begin
        if (ti < end_tick) begin
          chk("line_bit", {ser_en, ser_out}, {1'b1, exp_q[ti]});
          line_q.push_back(ser_out);
        end else if (under_exp) begin
          chk("underrun_flag", underrun, 1);
          chk("underrun_ser_en", ser_en, 0);
          chk("underrun_busy", busy, 0);
          fin = 1;
        end else begin
          chk("tail_done", done, 1);
          chk("tail_ser_en", {ser_en, ser_out}, 0);
          chk("tail_busy", busy, 0);
          fin = 1;
        end
        ti++;
        if (!fin && ti == abort_tick) begin
          rst_n = 1'b0; bit_tick = 1'b0; word_valid = 1'b0;
          @(posedge clk); #1;
          chk("rst_ser_en", ser_en, 0);
          chk("rst_busy", busy, 0);
          chk("rst_crc_clr", crc_clr, 1);
          chk("rst_word_ready", word_ready, 0);
          rst_n = 1'b1;
          @(posedge clk); #1;
          chk("rst_crc_value", crc_reg, 16'h0000);
          fin = 1; aborted = 1;
        end
      end
      bit_tick = !fin && cyc >= 6 && ((cyc - 6) % per == 0);
    end
    bit_tick = 1'b0; word_valid = 1'b0; start = 1'b0;
    chk("record_finished", fin, 1);
    if (fin && !aborted) begin
      repeat (3) begin
        @(posedge clk); #1;
        if (done) done_cnt++;
      end
      chk("done_count", done_cnt, under_exp ? 0 : 1);
      chk("handshakes", hs_cnt, under_exp ? n_supply : len);
      chk("crc_clr_pulses", clr_cnt, 1);
      chk("busy_after", busy, 0);
      if (len == 0) chk("ready_never", ready_seen, 0);
      if (!under_exp) begin
        chk("crc_stage_value", crc_reg, dcrc);
        chk("line_residue", ref_crc(line_q, line_q.size()), 16'h0000);
        chk("line_length", line_q.size(), nbits);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rec_len = '0; word_data = '0; word_valid = 1'b0; bit_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word_ready", word_ready, 0);
    chk("rst_outputs", {ser_out, ser_en, busy, done, underrun, crc_en}, 0);
    chk("rst_crc_clr", crc_clr, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_crc_clr", crc_clr, 0);

    words_q = '{16'h0000};
    run_record(1, 1, 4, 0, -1, -1);
    words_q = '{16'h0001, 16'h8000};
    run_record(2, 2, 4, 0, -1, -1);
    words_q.delete();
    run_record(0, 0, 5, 0, -1, -1);
    words_q = '{16'hA5C3, 16'h1234};
    run_record(2, 1, 4, 0, -1, -1);
    chk("underrun_sticky", underrun, 1);
    words_q = '{16'h0000};
    run_record(1, 1, 4, 0, -1, -1);
    words_q = '{16'hFFFF, 16'hBEEF};
    run_record(2, 2, 4, 0, 5, -1);
    words_q = '{16'h0000};
    run_record(1, 1, 4, 0, -1, -1);
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 6);
      words_q.delete();
      for (int w = 0; w < n; w++) words_q.push_back(16'($urandom));
      run_record(n, n, $urandom_range(4, 6), 12, -1, -1);
    end
    words_q.delete();
    for (int w = 0; w < 128; w++) words_q.push_back(16'($urandom));
    run_record(128, 128, 4, 20, -1, 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
